// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the SRAM arbiter and the cache controllers that sit on it:
// bus widths, arbiter state encoding and transaction op encoding.
package sram_arb_pkg;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int BLOCK_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } arb_op_t;

    // A request with both read and write high is treated as a write.
    function automatic arb_op_t decode_op(input logic read, input logic write);
        return write ? OP_WR : OP_RD;
    endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Level-request / ready-pulse memory bus. The same bus shape is used between a
// requester and the arbiter and between the arbiter and the SRAM controller.
interface sram_arbiter_if;
    import sram_arb_pkg::*;

    logic [ADDR_W-1:0]  address;
    logic [DATA_W-1:0]  wdata;
    logic               read;
    logic               write;
    logic [BLOCK_W-1:0] rdata;
    logic               ready;

    // Issues requests and waits for the ready pulse.
    modport master (
        output address, wdata, read, write,
        input  rdata, ready
    );

    // Accepts requests and returns data with a ready pulse.
    modport slave (
        input  address, wdata, read, write,
        output rdata, ready
    );

endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one SRAM controller between the data-cache port (p0)
// and the instruction-fetch port (p1). One transaction in flight; request fields are
// latched at grant, a watchdog aborts transactions the controller never completes,
// and an optional idle cycle after each completion keeps stale requests from re-granting.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 256,
    parameter int unsigned GAP     = 1
) (
    input  logic           clk,
    input  logic           rst,
    sram_arbiter_if.slave  p0,
    sram_arbiter_if.slave  p1,
    sram_arbiter_if.master sram,
    output logic           timeout_err
);

    localparam bit          WD_ON   = (TIMEOUT > 0);
    localparam bit          USE_GAP = (GAP != 0);
    localparam int unsigned CW      = WD_ON ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] WD_LAST = WD_ON ? CW'(TIMEOUT - 1) : '0;

    arb_state_t         state;
    logic               rr_ptr;
    logic               gnt;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               rd_q;
    logic               wr_q;
    logic [CW-1:0]      wd_count;

    logic               req0;
    logic               req1;
    logic               pick;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    arb_op_t            sel_op;
    logic               req_held;
    logic               done;
    logic               abort;
    logic               finish;

    // Grant selection and completion/abort detection.
    always_comb begin
        req0      = p0.read | p0.write;
        req1      = p1.read | p1.write;
        // Both requesting: rr_ptr decides; otherwise the single requester (p1 iff only p1).
        pick      = (req0 && req1) ? rr_ptr : req1;
        sel_addr  = pick ? p1.address : p0.address;
        sel_wdata = pick ? p1.wdata   : p0.wdata;
        sel_op    = pick ? decode_op(p1.read, p1.write) : decode_op(p0.read, p0.write);
        req_held  = gnt ? req1 : req0;
        done      = (state == ST_BUSY) && sram.ready;
        abort     = WD_ON && (state == ST_BUSY) && !sram.ready && (wd_count == WD_LAST);
        finish    = done || abort;
    end

    // Arbiter FSM: grant and latch in IDLE, hold strobes through BUSY, optional GAP cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            rr_ptr   <= 1'b0;
            gnt      <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            wd_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        gnt      <= pick;
                        rr_ptr   <= ~pick;
                        addr_q   <= sel_addr;
                        wdata_q  <= sel_wdata;
                        rd_q     <= (sel_op == OP_RD);
                        wr_q     <= (sel_op == OP_WR);
                        wd_count <= '0;
                        state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (finish) begin
                        rd_q  <= 1'b0;
                        wr_q  <= 1'b0;
                        state <= USE_GAP ? ST_GAP : ST_IDLE;
                    end else if (WD_ON) begin
                        wd_count <= wd_count + CW'(1);
                    end
                end
                ST_GAP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign sram.address = addr_q;
    assign sram.wdata   = wdata_q;
    assign sram.read    = rd_q;
    assign sram.write   = wr_q;

    // Route completion back to the granted port; dropped requests get no ready pulse.
    always_comb begin
        p0.ready    = 1'b0;
        p0.rdata    = '0;
        p1.ready    = 1'b0;
        p1.rdata    = '0;
        timeout_err = abort;
        if (finish && req_held) begin
            if (gnt) begin
                p1.ready = 1'b1;
                p1.rdata = done ? sram.rdata : '0;
            end else begin
                p0.ready = 1'b1;
                p0.rdata = done ? sram.rdata : '0;
            end
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed testbench for sram_arbiter with TIMEOUT=8, GAP=1: a table of single-requester
// transactions followed by hand sequences for round-robin, starvation, dropped requests
// and asynchronous reset.
module tb_sram_arbiter;
    import sram_arb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic timeout_err;

    int tests = 0;
    int fails = 0;

    sram_arbiter_if p0_bus ();
    sram_arbiter_if p1_bus ();
    sram_arbiter_if sram_bus ();

    sram_arbiter #(.TIMEOUT(8), .GAP(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .p0          (p0_bus),
        .p1          (p1_bus),
        .sram        (sram_bus),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        p0_rd;
        logic        p0_wr;
        logic        p1_rd;
        logic        p1_wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;      // BUSY cycle carrying sram_ready; 0 = never
        logic [63:0] blk;
        int          exp_port;
        logic        exp_wr;
        logic [63:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drop(input int port);
        if (port == 1) begin
            p1_bus.read  = 1'b0;
            p1_bus.write = 1'b0;
        end else begin
            p0_bus.read  = 1'b0;
            p0_bus.write = 1'b0;
        end
    endtask

    task automatic wait_strobe(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = ((sram_bus.read | sram_bus.write) === 1'b1);
        end
    endtask

    // One transaction from grant to the GAP cycle, acting as the SRAM controller.
    task automatic txn(input string tag, input int delay, input logic [63:0] blk,
                       input int port, input logic exp_wr, input logic [31:0] exp_addr,
                       input logic [31:0] exp_wdata, input logic [63:0] exp_rdata,
                       input logic exp_err, input bit release_req, input bit poke);
        bit seen;
        int c;
        int last;
        last = (delay != 0) ? delay : 8;
        wait_strobe(seen);
        check({tag, " grant"}, 64'(seen), 64'd1);
        if (!seen) return;
        check({tag, " addr"}, 64'(sram_bus.address), 64'(exp_addr));
        check({tag, " wdata"}, 64'(sram_bus.wdata), 64'(exp_wdata));
        if (poke) begin
            p0_bus.read    = 1'b1;
            p0_bus.write   = 1'b0;
            p0_bus.address = 32'h0000_3000;
            p0_bus.wdata   = 32'h5555_6666;
            p1_bus.address = 32'h0000_4444;
        end
        for (c = 1; c <= 16; c++) begin
            if (c > 1) @(negedge clk);
            if (c == last) begin
                sram_bus.rdata = blk;
                sram_bus.ready = (delay != 0);
                #1;
                break;
            end
            #1;
            check({tag, " hold"},
                  64'({sram_bus.read, sram_bus.write, p0_bus.ready, p1_bus.ready, timeout_err}),
                  64'({~exp_wr, exp_wr, 3'b000}));
            check({tag, " addr_hold"}, 64'(sram_bus.address), 64'(exp_addr));
        end
        check({tag, " cycles"}, 64'(c), 64'(last));
        check({tag, " ready"}, 64'({p1_bus.ready, p0_bus.ready}), (port == 1) ? 64'd2 : 64'd1);
        check({tag, " rdata"}, (port == 1) ? p1_bus.rdata : p0_bus.rdata, exp_rdata);
        check({tag, " rdata_other"}, (port == 1) ? p0_bus.rdata : p1_bus.rdata, 64'd0);
        check({tag, " err"}, 64'(timeout_err), 64'(exp_err));
        @(posedge clk);
        #1;
        sram_bus.ready = 1'b0;
        sram_bus.rdata = '0;
        if (release_req) drop(port);
        @(negedge clk);
        check({tag, " gap"},
              64'({sram_bus.read, sram_bus.write, p0_bus.ready, p1_bus.ready, timeout_err}), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit seen;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'h0000_0000, 4,
                    64'hAAAA_BBBB_CCCC_DDDD, 0, 1'b0, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h2000_0040, 32'h0BAD_0001, 1,
                    64'h0123_4567_89AB_CDEF, 1, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0300, 32'h1234_5678, 2,
                    64'hFEDC_BA98_7654_3210, 0, 1'b1, 64'hFEDC_BA98_7654_3210, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 8,
                    64'h5A5A_5A5A_5A5A_5A5A, 1, 1'b1, 64'h5A5A_5A5A_5A5A_5A5A, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0400, 32'h0000_0000, 0,
                    64'h1111_2222_3333_4444, 0, 1'b0, 64'h0, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0800, 32'hA5A5_0F0F, 0,
                    64'h9999_8888_7777_6666, 1, 1'b1, 64'h0, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 7,
                    64'hC3C3_C3C3_3C3C_3C3C, 0, 1'b1, 64'hC3C3_C3C3_3C3C_3C3C, 1'b0};

        rst = 1'b0;
        p0_bus.read = 1'b0;  p0_bus.write = 1'b0;  p0_bus.address = '0;  p0_bus.wdata = '0;
        p1_bus.read = 1'b0;  p1_bus.write = 1'b0;  p1_bus.address = '0;  p1_bus.wdata = '0;
        sram_bus.ready = 1'b0;
        sram_bus.rdata = '0;

        #12;
        check("reset strobes", 64'({sram_bus.read, sram_bus.write}), 64'd0);
        check("reset address", 64'(sram_bus.address), 64'd0);
        check("reset wdata", 64'(sram_bus.wdata), 64'd0);
        check("reset readies", 64'({p0_bus.ready, p1_bus.ready, timeout_err}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i < 7; i++) begin
            p0_bus.read    = vecs[i].p0_rd;
            p0_bus.write   = vecs[i].p0_wr;
            p1_bus.read    = vecs[i].p1_rd;
            p1_bus.write   = vecs[i].p1_wr;
            p0_bus.address = (vecs[i].exp_port == 0) ? vecs[i].addr  : ~vecs[i].addr;
            p0_bus.wdata   = (vecs[i].exp_port == 0) ? vecs[i].wdata : ~vecs[i].wdata;
            p1_bus.address = (vecs[i].exp_port == 1) ? vecs[i].addr  : ~vecs[i].addr;
            p1_bus.wdata   = (vecs[i].exp_port == 1) ? vecs[i].wdata : ~vecs[i].wdata;
            txn($sformatf("vec%0d", i), vecs[i].delay, vecs[i].blk, vecs[i].exp_port,
                vecs[i].exp_wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata,
                vecs[i].exp_err, 1'b1, 1'b0);
        end

        // Last grant went to p0, so rr_ptr is 1 here; reset must bring it back to 0.
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Simultaneous requests with rr_ptr=0: p0 first, GAP, then the held p1 write.
        p0_bus.read = 1'b1;  p0_bus.address = 32'h0000_1000;  p0_bus.wdata = 32'h0000_0000;
        p1_bus.write = 1'b1; p1_bus.address = 32'h0000_2000;  p1_bus.wdata = 32'hCAFE_F00D;
        txn("rr_a0", 3, 64'h1010_2020_3030_4040, 0, 1'b0, 32'h0000_1000, 32'h0000_0000,
            64'h1010_2020_3030_4040, 1'b0, 1'b1, 1'b0);
        txn("rr_a1", 2, 64'h5050_6060_7070_8080, 1, 1'b1, 32'h0000_2000, 32'hCAFE_F00D,
            64'h5050_6060_7070_8080, 1'b0, 1'b1, 1'b0);
        // A lone p0 transaction leaves rr_ptr=1, so the next tie goes to p1.
        p0_bus.read = 1'b1;  p0_bus.address = 32'h0000_1100;
        txn("rr_b", 1, 64'h0000_0000_0000_1100, 0, 1'b0, 32'h0000_1100, 32'h0000_0000,
            64'h0000_0000_0000_1100, 1'b0, 1'b1, 1'b0);
        p0_bus.write = 1'b1; p0_bus.address = 32'h0000_1200;  p0_bus.wdata = 32'h1111_2222;
        p1_bus.read = 1'b1;  p1_bus.address = 32'h0000_2200;  p1_bus.wdata = 32'h3333_4444;
        txn("rr_c1", 2, 64'h2200_2200_2200_2200, 1, 1'b0, 32'h0000_2200, 32'h3333_4444,
            64'h2200_2200_2200_2200, 1'b0, 1'b1, 1'b0);
        txn("rr_c0", 1, 64'h1200_1200_1200_1200, 0, 1'b1, 32'h0000_1200, 32'h1111_2222,
            64'h1200_1200_1200_1200, 1'b0, 1'b1, 1'b0);

        // p1 holds its request throughout; p0 arrives mid-BUSY and p1 changes its address
        // while granted. p0 must be next, then p1 again with the new address.
        p1_bus.read = 1'b1;  p1_bus.address = 32'h0000_4000;  p1_bus.wdata = 32'h0000_0000;
        txn("starve_p1", 3, 64'h4000_4000_4000_4000, 1, 1'b0, 32'h0000_4000, 32'h0000_0000,
            64'h4000_4000_4000_4000, 1'b0, 1'b0, 1'b1);
        txn("starve_p0", 2, 64'h3000_3000_3000_3000, 0, 1'b0, 32'h0000_3000, 32'h5555_6666,
            64'h3000_3000_3000_3000, 1'b0, 1'b1, 1'b0);
        txn("starve_p1b", 2, 64'h4444_4444_4444_4444, 1, 1'b0, 32'h0000_4444, 32'h0000_0000,
            64'h4444_4444_4444_4444, 1'b0, 1'b1, 1'b0);

        // p0 drops its request mid-BUSY: strobe stays up until sram_ready, no ready pulse.
        p0_bus.read = 1'b1;  p0_bus.address = 32'h0000_7000;
        wait_strobe(seen);
        check("drop grant", 64'(seen), 64'd1);
        p0_bus.read = 1'b0;
        @(negedge clk);
        sram_bus.ready = 1'b1;
        sram_bus.rdata = 64'h7777_7777_7777_7777;
        #1;
        check("drop strobe", 64'({sram_bus.read, sram_bus.write}), 64'd2);
        check("drop ready", 64'({p0_bus.ready, p1_bus.ready}), 64'd0);
        check("drop rdata", p0_bus.rdata, 64'd0);
        @(posedge clk);
        #1;
        sram_bus.ready = 1'b0;
        sram_bus.rdata = '0;
        @(negedge clk);
        check("drop release", 64'({sram_bus.read, sram_bus.write}), 64'd0);

        // Asynchronous reset in the middle of a read; p1 pending when reset releases.
        p0_bus.read = 1'b1;  p0_bus.address = 32'h0000_0500;
        wait_strobe(seen);
        check("rst busy", 64'(seen), 64'd1);
        @(negedge clk);
        #2;
        rst = 1'b0;
        p0_bus.read = 1'b0;
        p1_bus.read = 1'b1;  p1_bus.address = 32'h0000_0600;  p1_bus.wdata = 32'h0000_0066;
        #1;
        check("rst async strobes", 64'({sram_bus.read, sram_bus.write}), 64'd0);
        check("rst async address", 64'(sram_bus.address), 64'd0);
        check("rst async readies", 64'({p0_bus.ready, p1_bus.ready, timeout_err}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        txn("rst_p1", 2, 64'h0600_0600_0600_0600, 1, 1'b0, 32'h0000_0600, 32'h0000_0066,
            64'h0600_0600_0600_0600, 1'b0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
